// File: rtl/priority_encoder_3to2.sv
// Three independent 3-to-2 priority encoders: gate-level, dataflow and registered behavioural.
// Code {bit1,bit0}: request 3 -> 11, request 2 -> 10, request 1 -> 01, none -> 00.
module priority_encoder_3to2 (
    input  logic clk,
    input  logic rst,
    // gate-level channel
    input  logic q1,
    input  logic q2,
    input  logic q3,
    output wire  o1,
    output wire  o2,
    // dataflow channel
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic m1,
    output logic m2,
    // behavioural channel
    input  logic t1,
    input  logic t2,
    input  logic t3,
    output logic n1,
    output logic n2
);

    // Gate-level channel: bit0 = q3 | (~q2 & q1), bit1 = q3 | q2
    wire w_q2_n;
    wire w_q1_only;

    not g_q2_inv  (w_q2_n, q2);
    and g_q1_mask (w_q1_only, w_q2_n, q1);
    or  g_bit0    (o1, q3, w_q1_only);
    or  g_bit1    (o2, q3, q2);

    // Dataflow channel
    assign m2 = i3 | i2;
    assign m1 = i3 | (~i2 & i1);

    // Behavioural channel: code registered on the clock, no path from t to n in between
    logic [1:0] r_code;

    always_ff @(posedge clk) begin
        if (rst)
            r_code <= 2'b00;
        else if (t3)
            r_code <= 2'b11;
        else if (t2)
            r_code <= 2'b10;
        else if (t1)
            r_code <= 2'b01;
        else
            r_code <= 2'b00;
    end

    assign n1 = r_code[0];
    assign n2 = r_code[1];

endmodule

// File: tb/tb_priority_encoder_3to2.sv
// Self-checking bench for priority_encoder_3to2: vector table, directed reset and
// priority sequences, and random stimulus against a highest-set-bit reference model.
`timescale 1ns/1ps
module tb_priority_encoder_3to2;

    logic       clk;
    logic       rst;
    logic [2:0] q;
    logic [2:0] i;
    logic [2:0] t;
    wire        o1, o2;
    logic       m1, m2, n1, n2;

    int checks;
    int failures;

    priority_encoder_3to2 dut (
        .clk (clk),
        .rst (rst),
        .q1  (q[0]),
        .q2  (q[1]),
        .q3  (q[2]),
        .o1  (o1),
        .o2  (o2),
        .i1  (i[0]),
        .i2  (i[1]),
        .i3  (i[2]),
        .m1  (m1),
        .m2  (m2),
        .t1  (t[0]),
        .t2  (t[1]),
        .t3  (t[2]),
        .n1  (n1),
        .n2  (n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: code is the 1-based index of the highest asserted request, 0 if none.
    function automatic logic [1:0] enc(input logic [2:0] v);
        int code;
        code = 0;
        for (int k = 0; k < 3; k++)
            if (v[k] == 1'b1) code = k + 1;
        return code[1:0];
    endfunction

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (q=%b i=%b t=%b rst=%b)",
                     name, got, exp, q, i, t, rst);
        end
    endtask

    task automatic check_comb(input string name);
        check({name, "_o"}, {o2, o1}, enc(q));
        check({name, "_m"}, {m2, m1}, enc(i));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] in;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[8];
    logic [2:0] cnt;
    logic [1:0] n_hold;

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        q = 3'b000;
        i = 3'b000;
        t = 3'b000;

        vecs[0] = '{3'b000, 2'b00};
        vecs[1] = '{3'b001, 2'b01};
        vecs[2] = '{3'b010, 2'b10};
        vecs[3] = '{3'b011, 2'b10};
        vecs[4] = '{3'b100, 2'b11};
        vecs[5] = '{3'b101, 2'b11};
        vecs[6] = '{3'b110, 2'b11};
        vecs[7] = '{3'b111, 2'b11};

        // Reset state
        edge_step();
        check("reset_n", {n2, n1}, 2'b00);
        $display("txn reset: n=%b", {n2, n1});

        // Exhaustive combinational table
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            q = vecs[k].in;
            i = vecs[k].in;
            #1;
            check("table_o", {o2, o1}, vecs[k].exp);
            check("table_m", {m2, m1}, vecs[k].exp);
            check("table_o_eq_m", {o2, o1}, {m2, m1});
            $display("txn table in=%b o=%b m=%b", vecs[k].in, {o2, o1}, {m2, m1});
        end

        // Walking counter on all three channels
        @(negedge clk);
        rst = 1'b0;
        cnt = 3'b000;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            q = cnt;
            i = cnt;
            t = cnt;
            #1;
            check_comb("walk");
            edge_step();
            check("walk_n", {n2, n1}, enc(cnt));
            $display("txn walk x=%b o=%b m=%b n=%b", cnt, {o2, o1}, {m2, m1}, {n2, n1});
            cnt = cnt + 3'd1;
        end

        // Reset held three edges with t=111, then released
        @(negedge clk);
        rst = 1'b1;
        t = 3'b111;
        for (int k = 0; k < 3; k++) begin
            edge_step();
            check("rst_hold_n", {n2, n1}, 2'b00);
            $display("txn rst_hold edge=%0d n=%b", k, {n2, n1});
        end
        @(negedge clk);
        rst = 1'b0;
        edge_step();
        check("rst_release_n", {n2, n1}, 2'b11);
        $display("txn rst_release n=%b", {n2, n1});

        // Single-edge reset mid-stream with t=010, comb channels busy
        @(negedge clk);
        t = 3'b010;
        q = 3'b101;
        i = 3'b011;
        edge_step();
        check("mid_pre_n", {n2, n1}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_async_n", {n2, n1}, 2'b10);
        check_comb("mid_rst");
        edge_step();
        check("mid_rst_n", {n2, n1}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        edge_step();
        check("mid_after_n", {n2, n1}, 2'b10);
        check_comb("mid_after");
        $display("txn mid_reset n=%b o=%b m=%b", {n2, n1}, {o2, o1}, {m2, m1});

        // Reset pulse entirely between edges must be ignored
        @(negedge clk);
        t = 3'b001;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        edge_step();
        check("glitch_rst_n", {n2, n1}, 2'b01);
        $display("txn glitch_rst n=%b", {n2, n1});

        // Priority override: t1 held, t3 pulsed for one cycle
        @(negedge clk);
        t = 3'b001;
        edge_step();
        check("prio_a_n", {n2, n1}, 2'b01);
        @(negedge clk);
        t = 3'b101;
        edge_step();
        check("prio_b_n", {n2, n1}, 2'b11);
        @(negedge clk);
        t = 3'b001;
        edge_step();
        check("prio_c_n", {n2, n1}, 2'b01);
        $display("txn priority_override n=%b", {n2, n1});

        // Channel independence
        @(negedge clk);
        q = 3'b100;
        i = 3'b001;
        t = 3'b010;
        #1;
        check("indep_o", {o2, o1}, 2'b11);
        check("indep_m", {m2, m1}, 2'b01);
        edge_step();
        check("indep_n", {n2, n1}, 2'b10);
        $display("txn independence o=%b m=%b n=%b", {o2, o1}, {m2, m1}, {n2, n1});

        // Randomized stimulus, independent values per channel, occasional reset
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            q = 3'($urandom_range(0, 7));
            i = 3'($urandom_range(0, 7));
            t = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 15) == 0);
            #1;
            check_comb("rand");
            n_hold = rst ? 2'b00 : enc(t);
            edge_step();
            check("rand_n", {n2, n1}, n_hold);
            $display("txn rand q=%b i=%b t=%b rst=%b o=%b m=%b n=%b",
                     q, i, t, rst, {o2, o1}, {m2, m1}, {n2, n1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
